// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, the byte-wide instruction ROM and the control unit.
// The master modport is the fetch unit's side of the bundle.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 9
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;

    modport master (
        output mem_rd, mem_addr, instr, instr_valid, pc,
        input  mem_rdata, instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  mem_rd, mem_addr, instr, instr_valid, pc,
        output mem_rdata, instr_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Reads four ROM bytes per instruction, assembles them big-endian and hands the word to
// the control unit; the PC/nPC pair gives redirects a single delay-slot instruction.
module instr_fetch_unit #(
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               clr,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] NPC_INIT  = PC_INIT + WORD_STEP;

    state_t            state, state_next;
    logic [1:0]        cnt, cnt_next;
    logic [ADDR_W-1:0] pc_q, npc_q;
    logic [31:0]       instr_q;
    logic              valid_q, valid_next;
    logic              accept;
    logic              fetch_rd;
    logic              rd_pending;
    logic [1:0]        rd_idx;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        valid_next = valid_q;
        accept     = 1'b0;
        case (state)
            FETCH: begin
                cnt_next = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                valid_next = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (valid_q && bus.instr_ready) begin
                    accept     = 1'b1;
                    valid_next = 1'b0;
                    cnt_next   = 2'd0;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // The strobe is gated by clr so the bus goes quiet the instant reset is asserted.
    assign fetch_rd        = (state == FETCH) && !clr;
    assign bus.mem_rd      = fetch_rd;
    assign bus.mem_addr    = fetch_rd ? (pc_q + {{(ADDR_W-2){1'b0}}, cnt}) : '0;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= FETCH;
            cnt        <= 2'd0;
            pc_q       <= PC_INIT;
            npc_q      <= NPC_INIT;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            rd_pending <= 1'b0;
            rd_idx     <= 2'd0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            valid_q    <= valid_next;
            rd_pending <= fetch_rd;
            rd_idx     <= cnt;
            // Only the cycle after a request carries a real byte; other cycles may be X.
            if (rd_pending) begin
                case (rd_idx)
                    2'd0: instr_q[31:24] <= bus.mem_rdata;
                    2'd1: instr_q[23:16] <= bus.mem_rdata;
                    2'd2: instr_q[15:8]  <= bus.mem_rdata;
                    2'd3: instr_q[7:0]   <= bus.mem_rdata;
                endcase
            end
            if (accept) begin
                pc_q  <= npc_q;
                npc_q <= bus.redirect_valid ? {bus.redirect_target[ADDR_W-1:2], 2'b00}
                                            : npc_q + WORD_STEP;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (reset PC 0 and 508) share one ROM image and
// all control inputs, and are checked every cycle against a phase-counting PC/nPC model.
module tb_instr_fetch_unit;
    localparam int ADDR_W = 9;
    localparam int RPC0   = 0;
    localparam int RPC1   = 508;

    logic              clk    = 1'b0;
    logic              clr    = 1'b0;
    logic              ready  = 1'b0;
    logic              redir  = 1'b0;
    logic [ADDR_W-1:0] target = '0;
    logic [7:0]        rom [512];
    logic [7:0]        rdata0, rdata1;
    int                compared   = 0;
    int                mismatched = 0;

    logic              d_rd    [2];
    logic [ADDR_W-1:0] d_addr  [2];
    logic [ADDR_W-1:0] d_pc    [2];
    logic [31:0]       d_instr [2];
    logic              d_valid [2];

    logic [ADDR_W-1:0] m_pc    [2];
    logic [ADDR_W-1:0] m_npc   [2];
    int                m_phase [2];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus0 ();
    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus1 ();

    assign bus0.mem_rdata       = rdata0;
    assign bus0.instr_ready     = ready;
    assign bus0.redirect_valid  = redir;
    assign bus0.redirect_target = target;
    assign bus1.mem_rdata       = rdata1;
    assign bus1.instr_ready     = ready;
    assign bus1.redirect_valid  = redir;
    assign bus1.redirect_target = target;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RPC0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));
    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RPC1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));

    assign d_rd[0]    = bus0.mem_rd;
    assign d_addr[0]  = bus0.mem_addr;
    assign d_pc[0]    = bus0.pc;
    assign d_instr[0] = bus0.instr;
    assign d_valid[0] = bus0.instr_valid;
    assign d_rd[1]    = bus1.mem_rd;
    assign d_addr[1]  = bus1.mem_addr;
    assign d_pc[1]    = bus1.pc;
    assign d_instr[1] = bus1.instr;
    assign d_valid[1] = bus1.instr_valid;

    // Registered ROM: data one cycle after the address is sampled, X otherwise.
    always @(posedge clk) begin
        rdata0 <= bus0.mem_rd ? rom[bus0.mem_addr] : 8'hxx;
        rdata1 <= bus1.mem_rd ? rom[bus1.mem_addr] : 8'hxx;
    end

    function automatic int rst_pc(input int i);
        return (i == 0) ? RPC0 : RPC1;
    endfunction

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] a1, a2, a3;
        a1 = a + 9'd1;
        a2 = a + 9'd2;
        a3 = a + 9'd3;
        return {rom[a], rom[a1], rom[a2], rom[a3]};
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [ADDR_W-1:0] t);
        @(negedge clk);
        ready  = r;
        redir  = rv;
        target = t;
    endtask

    // Phase 0..3 request bytes, 4 waits for the last byte, 5 presents the word until taken.
    always @(posedge clk or posedge clr) begin
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_pc[i]    = ADDR_W'(rst_pc(i));
                m_npc[i]   = ADDR_W'(rst_pc(i) + 4);
                m_phase[i] = 0;
            end else if (m_phase[i] < 5) begin
                m_phase[i]++;
            end else if (ready) begin
                m_pc[i]    = m_npc[i];
                m_npc[i]   = redir ? {target[ADDR_W-1:2], 2'b00} : m_npc[i] + 9'd4;
                m_phase[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                checkOutput("rst_rd", i, 32'(d_rd[i]), 32'd0);
                checkOutput("rst_addr", i, 32'(d_addr[i]), 32'd0);
                checkOutput("rst_valid", i, 32'(d_valid[i]), 32'd0);
                checkOutput("rst_instr", i, d_instr[i], 32'd0);
                checkOutput("rst_pc", i, 32'(d_pc[i]), 32'(rst_pc(i)));
            end else begin
                checkOutput("valid", i, 32'(d_valid[i]), 32'(m_phase[i] == 5));
                if (m_phase[i] < 4) begin
                    checkOutput("mem_rd", i, 32'(d_rd[i]), 32'd1);
                    checkOutput("mem_addr", i, 32'(d_addr[i]),
                                32'(ADDR_W'(m_pc[i] + ADDR_W'(m_phase[i]))));
                end else begin
                    checkOutput("mem_rd_idle", i, 32'(d_rd[i]), 32'd0);
                end
                if (m_phase[i] == 5) begin
                    checkOutput("instr", i, d_instr[i], word_at(m_pc[i]));
                    checkOutput("pc", i, 32'(d_pc[i]), 32'(m_pc[i]));
                end
            end
        end
    end

    task automatic checkResetNow();
        checkOutput("async_rst_rd", 0, 32'(d_rd[0]), 32'd0);
        checkOutput("async_rst_addr", 0, 32'(d_addr[0]), 32'd0);
        checkOutput("async_rst_valid", 0, 32'(d_valid[0]), 32'd0);
        checkOutput("async_rst_instr", 0, d_instr[0], 32'd0);
        checkOutput("async_rst_pc", 0, 32'(d_pc[0]), 32'd0);
        checkOutput("async_rst_pc", 1, 32'(d_pc[1]), 32'd508);
    endtask

    // Counts edges from reset release until valid; also pins the byte address sequence.
    task automatic waitFirstValid(output int n);
        n = 0;
        while (!d_valid[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n <= 3) begin
                checkOutput("first_addr_seq", 0, 32'(d_addr[0]), 32'(n));
                checkOutput("wrap_addr_seq", 1, 32'(d_addr[1]), 32'((508 + n) % 512));
            end
        end
        checkOutput("valid_seen", 0, 32'(d_valid[0]), 32'd1);
    endtask

    task automatic waitNextValid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (d_valid[0] && n < 40);
        while (!d_valid[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("valid_seen", 0, 32'(d_valid[0]), 32'd1);
    endtask

    task automatic runBranch(input logic [ADDR_W-1:0] tgt);
        int n;
        waitFirstValid(n);
        checkOutput("restart_latency", 0, 32'(n), 32'd5);
        checkOutput("restart_instr", 0, d_instr[0], 32'h82102005);
        waitNextValid(n);
        checkOutput("pre_branch_pc", 0, 32'(d_pc[0]), 32'd4);
        waitNextValid(n);
        checkOutput("branch_pc", 0, 32'(d_pc[0]), 32'd8);
        redir  = 1'b1;
        target = tgt;
        waitNextValid(n);
        redir  = 1'b0;
        target = '0;
        checkOutput("delay_slot_pc", 0, 32'(d_pc[0]), 32'd12);
        waitNextValid(n);
        checkOutput("branch_target_pc", 0, 32'(d_pc[0]), 32'h40);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int                n;
        logic [31:0]       held_instr;
        logic [ADDR_W-1:0] held_pc;
        for (int a = 0; a < 512; a++) rom[a] = 8'($urandom);
        rom[0] = 8'h82;
        rom[1] = 8'h10;
        rom[2] = 8'h20;
        rom[3] = 8'h05;

        #1 clr = 1'b1;
        repeat (2) @(negedge clk);
        checkResetNow();
        @(posedge clk);
        #2;
        clr   = 1'b0;
        ready = 1'b1;
        #1;
        checkOutput("first_addr", 0, 32'(d_addr[0]), 32'd0);
        checkOutput("first_rd", 0, 32'(d_rd[0]), 32'd1);

        $display("[TB] first fetch and sequential stream");
        waitFirstValid(n);
        checkOutput("first_latency", 0, 32'(n), 32'd5);
        checkOutput("first_instr", 0, d_instr[0], 32'h82102005);
        checkOutput("first_pc", 0, 32'(d_pc[0]), 32'd0);
        checkOutput("wrap_first_pc", 1, 32'(d_pc[1]), 32'd508);
        for (int w = 1; w < 4; w++) begin
            waitNextValid(n);
            checkOutput("stream_gap", 0, 32'(n), 32'd6);
            checkOutput("stream_pc", 0, 32'(d_pc[0]), 32'(4 * w));
            checkOutput("wrap_pc", 1, 32'(d_pc[1]), 32'((508 + 4 * w) % 512));
        end

        $display("[TB] backpressure");
        waitNextValid(n);
        ready      = 1'b0;
        held_instr = d_instr[0];
        held_pc    = d_pc[0];
        checkOutput("bp_pc", 0, 32'(held_pc), 32'd16);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp_valid", 0, 32'(d_valid[0]), 32'd1);
            checkOutput("bp_instr", 0, d_instr[0], held_instr);
            checkOutput("bp_pc_hold", 0, 32'(d_pc[0]), 32'(held_pc));
            checkOutput("bp_no_rd", 0, 32'(d_rd[0]), 32'd0);
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_next_rd", 0, 32'(d_rd[0]), 32'd1);
        checkOutput("bp_next_addr", 0, 32'(d_addr[0]), 32'(held_pc + 9'd4));

        $display("[TB] randomized ready/redirect traffic");
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                          ADDR_W'($urandom));
        end
        applyStimulus(1'b1, 1'b0, '0);

        $display("[TB] reset mid-fetch, then delayed branch");
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (m_phase[0] == 2) break;
        end
        clr = 1'b1;
        #1;
        checkResetNow();
        repeat (2) @(posedge clk);
        #2 clr = 1'b0;
        runBranch(9'h040);

        $display("[TB] reset in hold, then branch to unaligned target");
        ready = 1'b0;
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        checkResetNow();
        repeat (2) @(posedge clk);
        #2;
        clr   = 1'b0;
        ready = 1'b1;
        runBranch(9'h043);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
